// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter width and controller state encoding.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_line_counter.sv
// Wrap-around counter with synchronous clear; exposes the next value so the
// parent can register outputs decoded from it.
module vga_line_counter #(
    parameter int WIDTH = 10,
    parameter int TOTAL = 800
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    always_comb begin
        wrap       = enable && (count == LAST);
        count_next = count;
        if (clear)
            count_next = '0;
        else if (wrap)
            count_next = '0;
        else if (enable)
            count_next = count + 1'b1;
    end

    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA sync/blank generator with IDLE/RUN/DRAIN control; frames are never cut short.
// Optional 16-bit frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic             run,
    output logic             h_synch,
    output logic             v_synch,
    output logic             comp_synch,
    output logic             blank,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]      frame_count,
`endif
    output logic             busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One extra bit so sync-end boundaries equal to 1024 still compare correctly.
    localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] H_SS      = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] H_SE      = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] V_SS      = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] V_SE      = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    vga_state_e       state, state_nxt;
    logic             active;
    logic             h_wrap, v_wrap;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic [CNT_W:0]   hx, vx;
    logic             fs_nxt, on_nxt;

    assign active = (state != ST_IDLE);

    vga_line_counter #(.WIDTH(CNT_W), .TOTAL(H_TOTAL)) u_h_cnt (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .clear       (!active),
        .enable      (active),
        .count       (pixel_x),
        .count_next  (h_nxt),
        .wrap        (h_wrap)
    );

    vga_line_counter #(.WIDTH(CNT_W), .TOTAL(V_TOTAL)) u_v_cnt (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .clear       (!active),
        .enable      (h_wrap),
        .count       (pixel_y),
        .count_next  (v_nxt),
        .wrap        (v_wrap)
    );

    // v_wrap only fires on the last pixel of the last line: the frame boundary.
    always_comb begin
        state_nxt = state;
        fs_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_RUN;
                    fs_nxt    = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (v_wrap) begin
                    state_nxt = run ? ST_RUN : ST_IDLE;
                    fs_nxt    = run;
                end else begin
                    state_nxt = run ? ST_RUN : ST_DRAIN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign on_nxt = (state_nxt != ST_IDLE);
    assign hx     = {1'b0, h_nxt};
    assign vx     = {1'b0, v_nxt};

    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            h_synch     <= 1'b1;
            v_synch     <= 1'b1;
            comp_synch  <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            h_synch     <= !(on_nxt && hx >= H_SS && hx < H_SE);
            v_synch     <= !(on_nxt && vx >= V_SS && vx < V_SE);
            comp_synch  <= !(on_nxt && hx >= H_SS && hx < H_SE) &&
                           !(on_nxt && vx >= V_SS && vx < V_SE);
            blank       <= !on_nxt || hx >= H_ACT_END || vx >= V_ACT_END;
            frame_start <= fs_nxt;
            busy        <= on_nxt;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset)
            frame_count <= '0;
        else if (fs_nxt)
            frame_count <= frame_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized run/reset stimulus against a frame-position model of the VGA controller.
module tb_vga_timing_ctrl;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 17
    localparam int FRAME = HT * VT;          // 425

    logic       pixel_clock = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       h_synch, v_synch, comp_synch, blank, frame_start, busy;
    logic [9:0] pixel_x, pixel_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .run         (run),
        .h_synch     (h_synch),
        .v_synch     (v_synch),
        .comp_synch  (comp_synch),
        .blank       (blank),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_count (frame_count),
`endif
        .busy        (busy)
    );

    always #5 pixel_clock = ~pixel_clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Model: position within the frame while active; frame ends decide continue/stop.
    logic        m_act = 1'b0;
    logic        m_fs = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_frames = '0;

    always @(posedge pixel_clock) cyc <= cyc + 1;

    always @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            m_act <= 1'b0; m_pos <= 0; m_fs <= 1'b0; m_frames <= '0;
        end else if (!m_act) begin
            m_pos <= 0;
            m_fs  <= run;
            if (run) begin
                m_act    <= 1'b1;
                m_frames <= m_frames + 16'd1;
            end
        end else if (m_pos == FRAME - 1) begin
            m_pos <= 0;
            m_fs  <= run;
            m_act <= run;
            if (run) m_frames <= m_frames + 16'd1;
        end else begin
            m_pos <= m_pos + 1;
            m_fs  <= 1'b0;
        end
    end

    int   e_h, e_v;
    logic e_hs, e_vs, e_bl;

    initial forever begin
        @(negedge pixel_clock);
        e_h  = m_act ? m_pos % HT : 0;
        e_v  = m_act ? m_pos / HT : 0;
        e_hs = !(m_act && e_h >= HA + HF && e_h < HA + HF + HS);
        e_vs = !(m_act && e_v >= VA + VF && e_v < VA + VF + VS);
        e_bl = !m_act || e_h >= HA || e_v >= VA;
        chk("pixel_x", 32'(pixel_x), 32'(e_h));
        chk("pixel_y", 32'(pixel_y), 32'(e_v));
        chk("h_synch", 32'(h_synch), 32'(e_hs));
        chk("v_synch", 32'(v_synch), 32'(e_vs));
        chk("comp_synch", 32'(comp_synch), 32'(e_hs & e_vs));
        chk("blank", 32'(blank), 32'(e_bl));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("busy", 32'(busy), 32'(m_act));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_count", 32'(frame_count), 32'(m_frames));
`endif
    end

    task automatic wait_xy(input int x, input int y);
        int n;
        n = 0;
        while (!(pixel_x == 10'(x) && pixel_y == 10'(y)) && n < 2 * FRAME) begin
            @(negedge pixel_clock);
            n++;
        end
        chk("wait_xy_timeout", 32'(n < 2 * FRAME), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int nb, hl, hs_first, vl, n, t0;

    initial begin
        repeat (3) @(negedge pixel_clock);
        chk("rst_h_synch", 32'(h_synch), 32'd1);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pixel_x", 32'(pixel_x), 32'd0);

        reset = 1'b1;
        run   = 1'b1;
        @(negedge pixel_clock);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_blank", 32'(blank), 32'd0);
        chk("first_busy", 32'(busy), 32'd1);

        // One whole frame measured from the frame_start cycle.
        nb = 0; hl = 0; hs_first = -1; vl = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge pixel_clock);
            if (!blank) nb++;
            if (!h_synch && pixel_y == 10'd0) begin
                hl++;
                if (hs_first < 0) hs_first = int'(pixel_x);
            end
            if (!v_synch) vl++;
        end
        @(negedge pixel_clock);
        chk("frame_period_fs", 32'(frame_start), 32'd1);
        chk("active_pixels", 32'(nb), 32'd160);
        chk("hsync_line0_len", 32'(hl), 32'd4);
        chk("hsync_line0_start", 32'(hs_first), 32'd18);
        chk("vsync_cycles", 32'(vl), 32'd50);

        // Drop run at line 4: the frame completes, then idle.
        wait_xy(0, 4);
        run = 1'b0;
        n = 0;
        while (busy && n < 2 * FRAME) begin
            @(negedge pixel_clock);
            n++;
        end
        chk("drain_len", 32'(n), 32'(FRAME - 4 * HT));
        chk("drain_idle_blank", 32'(blank), 32'd1);

        // Drop run at line 4, restore at line 8: no gap in timing.
        run = 1'b1;
        @(negedge pixel_clock);
        chk("restart_fs", 32'(frame_start), 32'd1);
        t0 = cyc;
        wait_xy(0, 4);
        run = 1'b0;
        wait_xy(0, 8);
        run = 1'b1;
        @(negedge pixel_clock);
        n = 0;
        while (!frame_start && n < 2 * FRAME) begin
            @(negedge pixel_clock);
            n++;
        end
        chk("resume_period", 32'(cyc - t0), 32'(FRAME));

        // Asynchronous reset while both syncs are asserted.
        wait_xy(20, 12);
        chk("pre_rst_h_synch", 32'(h_synch), 32'd0);
        chk("pre_rst_v_synch", 32'(v_synch), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("async_h_synch", 32'(h_synch), 32'd1);
        chk("async_v_synch", 32'(v_synch), 32'd1);
        chk("async_blank", 32'(blank), 32'd1);
        chk("async_pixel_x", 32'(pixel_x), 32'd0);
        chk("async_pixel_y", 32'(pixel_y), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge pixel_clock);
        reset = 1'b1;

        // Random run toggling with rare reset pulses between edges.
        for (int i = 0; i < 9000; i++) begin
            @(negedge pixel_clock);
            if ($urandom_range(0, 249) == 0) run = ~run;
            if ($urandom_range(0, 2999) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        run = 1'b0;
        repeat (2) @(negedge pixel_clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameters SHALL be one per line as follows:
  H_ACTIVE 640 visible pixels/line
  H_FP 16 h front porch
  H_SYNC 96 h sync width
  H_BP 48 h back porch
  V_ACTIVE 480 visible lines
  V_FP 10 v front porch
  V_SYNC 2 v sync width
  V_BP 33 v back porch
REQ-002 Ports SHALL be one per line as follows:
  pixel_clock  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset
  run  in  1  level request to generate frames
  h_synch  out  1  horizontal sync, active-low
  v_synch  out  1  vertical sync, active-low
  comp_synch  out  1  composite sync, h_synch AND v_synch
  blank  out  1  high outside active area or when idle
  pixel_x  out  10  current column (h count)
  pixel_y  out  10  current line (v count)
  frame_start  out  1  one-cycle pulse at h=0,v=0 while RUN
  busy  out  1  high in RUN or DRAIN

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525 default); counters 10 bits, all parameters SHALL satisfy totals <= 1024.
REQ-004 FSM states IDLE, RUN, DRAIN; encoding 2 bits.
REQ-005 IDLE: h/v counters held 0, h_synch=1, v_synch=1, comp_synch=1, blank=1, frame_start=0, busy=0.
REQ-006 IDLE->RUN on first edge with run=1; that edge loads h=0,v=0 and asserts frame_start for exactly that cycle.
REQ-007 RUN/DRAIN: h increments each cycle, wraps H_TOTAL-1->0; v increments on h wrap, wraps V_TOTAL-1->0.
REQ-008 All outputs SHALL be registers decoded from the next-state counter values, so outputs and pixel_x/pixel_y change on the same edge (zero-cycle skew between sync, blank and coordinates).
REQ-009 h_synch=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751 default).
REQ-010 v_synch=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491 default).
REQ-011 blank=1 iff h >= H_ACTIVE or v >= V_ACTIVE.
REQ-012 RUN->DRAIN when run=0; DRAIN continues timing unchanged.
REQ-013 DRAIN->IDLE on the edge after h=H_TOTAL-1,v=V_TOTAL-1; no partial frame is ever emitted.
REQ-014 DRAIN->RUN if run=1 again before frame end; timing continues with no gap or counter reset.
REQ-015 frame_start SHALL pulse at every h=0,v=0 in RUN, never in DRAIN wrap (DRAIN ends instead).

Reset
REQ-016 reset=0 SHALL asynchronously force IDLE state and all REQ-005 output values, mid-frame included.
REQ-017 Reset release SHALL be synchronous; first RUN entry requires run=1 sampled after release.

Configuration
REQ-018 Macro VGA_TIMING_FRAME_CNT_EN defined: extra output frame_count (16 bits), reset 0, increments on each frame_start, wraps 65535->0, holds in IDLE.
REQ-019 Macro undefined: port frame_count absent, no counter logic.

Structure
REQ-020 Package vga_timing_pkg SHALL hold default timing constants, totals, counter width and FSM state encoding.
REQ-021 One sub-module vga_line_counter (parameterized wrap counter with enable and wrap pulse), instantiated for h and v.

Verification
REQ-022 Reset then run=1: frame_start at cycle 1, h_synch low exactly cycles 656..751 of line 0, period 800.
REQ-023 Full frame: v_synch low only during lines 490..491; blank=0 count per frame = 307200; frame period 420000 cycles.
REQ-024 run=0 at line 100: outputs continue to h=799,v=524, then IDLE values, busy=0.
REQ-025 run=0 at line 100, run=1 at line 300: no gap, next frame_start at cycle 420000 after previous.
REQ-026 reset=0 at h=700,v=491: same cycle h_synch=1, v_synch=1, blank=1, pixel_x=0, pixel_y=0.
REQ-027 With VGA_TIMING_FRAME_CNT_EN, 3 frames: frame_count=3; preset near 65535 wraps to 0.
